// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared state, lane-mask and request-kind encodings for the memory responder
package cpu_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_GRANT,
    S_IO_ACCESS,
    S_READ_DATA,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_STORE,
    K_LOAD,
    K_POKE,
    K_PEEK
  } kind_t;

  localparam logic [1:0] MASK_WORD = 2'b11;
  localparam logic [1:0] MASK_HI   = 2'b10;
  localparam logic [1:0] MASK_LO   = 2'b01;

endpackage

// File: rtl/load_byte_align.sv
// rtl/load_byte_align.sv - moves the selected byte lane to [7:0] and zero/sign-extends it
module load_byte_align
  import cpu_mem_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic [BITS-1:0] i_data,
  input  logic [1:0]      i_mask,
  input  logic            i_sx,
  output logic [BITS-1:0] o_data
);

  logic [7:0] w_byte;
  logic       w_is_byte;

  assign w_byte    = (i_mask == MASK_HI) ? i_data[15:8] : i_data[7:0];
  assign w_is_byte = (i_mask == MASK_HI) || (i_mask == MASK_LO);
  assign o_data    = w_is_byte ? {{(BITS-8){i_sx & w_byte[7]}}, w_byte} : i_data;

endmodule

// File: rtl/cpu_memory_responder.sv
// rtl/cpu_memory_responder.sv - serves execute-stage load/store/peek/poke via the arbiter or IO bus and stalls until done
module cpu_memory_responder
  import cpu_mem_pkg::*;
#(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    load_memory,
  input  logic                    store_memory,
  input  logic [ADDRESS_BITS-1:0] load_store_address,
  input  logic [BITS-1:0]         memory_out,
  input  logic [1:0]              memory_wr_mask,
  input  logic                    load_sx,
  input  logic                    port_rd,
  input  logic                    port_wr,
  input  logic [ADDRESS_BITS-1:0] port_address,
  input  logic [BITS-1:0]         port_out,
  output logic                    stall,
  output logic                    result_valid,
  output logic [BITS-1:0]         result_data,
  output logic                    bus_request,
  input  logic                    bus_grant,
  output logic [ADDRESS_BITS-2:0] bus_addr,
  output logic                    bus_wr,
  output logic [1:0]              bus_wr_mask,
  output logic [BITS-1:0]         bus_data_out,
  input  logic [BITS-1:0]         bus_data_in,
  output logic [ADDRESS_BITS-1:0] io_addr,
  output logic                    io_rd,
  output logic                    io_wr,
  output logic [BITS-1:0]         io_data_out,
  input  logic [BITS-1:0]         io_data_in
);

  state_t                  r_state;
  kind_t                   r_kind;
  logic [ADDRESS_BITS-1:0] r_addr;
  logic [BITS-1:0]         r_data;
  logic [1:0]              r_mask;
  logic                    r_sx;
  logic                    r_bus_request;
  logic                    r_bus_wr;
  logic                    r_io_rd;
  logic                    r_io_wr;
  logic                    r_result_valid;
  logic [BITS-1:0]         r_result_data;

  logic                    w_any_req;
  logic [BITS-1:0]         w_raw;
  logic [1:0]              w_align_mask;
  logic [BITS-1:0]         w_aligned;

  assign w_any_req = load_memory | store_memory | port_rd | port_wr;
  assign stall     = ((r_state == S_IDLE) && w_any_req) ||
                     ((r_state != S_IDLE) && (r_state != S_DONE));

  // IO reads bypass lane selection by forcing the word mask into the shared aligner
  assign w_raw        = (r_kind == K_PEEK) ? io_data_in : bus_data_in;
  assign w_align_mask = (r_kind == K_PEEK) ? MASK_WORD : r_mask;

  load_byte_align #(.BITS(BITS)) u_align (
    .i_data (w_raw),
    .i_mask (w_align_mask),
    .i_sx   (r_sx),
    .o_data (w_aligned)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state        <= S_IDLE;
      r_kind         <= K_STORE;
      r_addr         <= '0;
      r_data         <= '0;
      r_mask         <= '0;
      r_sx           <= 1'b0;
      r_bus_request  <= 1'b0;
      r_bus_wr       <= 1'b0;
      r_io_rd        <= 1'b0;
      r_io_wr        <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_result_valid <= 1'b0;
          if (store_memory || load_memory) begin
            r_kind        <= store_memory ? K_STORE : K_LOAD;
            r_addr        <= load_store_address;
            r_data        <= memory_out;
            r_mask        <= memory_wr_mask;
            r_sx          <= load_sx;
            r_bus_request <= 1'b1;
            r_bus_wr      <= store_memory;
            r_state       <= S_WAIT_GRANT;
          end else if (port_wr || port_rd) begin
            r_kind  <= port_wr ? K_POKE : K_PEEK;
            r_addr  <= port_address;
            r_data  <= port_out;
            r_mask  <= MASK_WORD;
            r_sx    <= 1'b0;
            r_io_wr <= port_wr;
            r_io_rd <= ~port_wr;
            r_state <= S_IO_ACCESS;
          end
        end
        S_WAIT_GRANT: begin
          if (bus_grant) begin
            r_bus_request <= 1'b0;
            r_bus_wr      <= 1'b0;
            if (r_kind == K_STORE) r_state <= S_DONE;
            else                   r_state <= S_READ_DATA;
          end
        end
        S_IO_ACCESS: begin
          r_io_rd <= 1'b0;
          r_io_wr <= 1'b0;
          if (r_kind == K_POKE) r_state <= S_DONE;
          else                  r_state <= S_READ_DATA;
        end
        S_READ_DATA: begin
          r_result_data  <= w_aligned;
          r_result_valid <= 1'b1;
          r_state        <= S_DONE;
        end
        S_DONE: begin
          r_result_valid <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result_valid = r_result_valid;
  assign result_data  = r_result_data;
  assign bus_request  = r_bus_request;
  assign bus_wr       = r_bus_wr;
  assign bus_addr     = r_addr[ADDRESS_BITS-1:1];
  assign bus_wr_mask  = r_mask;
  assign bus_data_out = r_data;
  assign io_addr      = r_addr;
  assign io_rd        = r_io_rd;
  assign io_wr        = r_io_wr;
  assign io_data_out  = r_data;

endmodule

// File: tb/tb_cpu_memory_responder.sv
// tb/tb_cpu_memory_responder.sv - directed self-checking bench with a per-access timeline model
module tb_cpu_memory_responder;

  localparam int K_STORE = 0;
  localparam int K_LOAD  = 1;
  localparam int K_POKE  = 2;
  localparam int K_PEEK  = 3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        load_memory, store_memory, load_sx, port_rd, port_wr, bus_grant;
  logic [15:0] load_store_address, memory_out, port_address, port_out, bus_data_in, io_data_in;
  logic [1:0]  memory_wr_mask;
  logic        stall, result_valid, bus_request, bus_wr, io_rd, io_wr;
  logic [15:0] result_data, bus_data_out, io_addr, io_data_out;
  logic [14:0] bus_addr;
  logic [1:0]  bus_wr_mask;

  cpu_memory_responder #(.BITS(16), .ADDRESS_BITS(16)) dut (
    .CLK(CLK), .RST(RST),
    .load_memory(load_memory), .store_memory(store_memory),
    .load_store_address(load_store_address), .memory_out(memory_out),
    .memory_wr_mask(memory_wr_mask), .load_sx(load_sx),
    .port_rd(port_rd), .port_wr(port_wr), .port_address(port_address), .port_out(port_out),
    .stall(stall), .result_valid(result_valid), .result_data(result_data),
    .bus_request(bus_request), .bus_grant(bus_grant), .bus_addr(bus_addr), .bus_wr(bus_wr),
    .bus_wr_mask(bus_wr_mask), .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
    .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr), .io_data_out(io_data_out),
    .io_data_in(io_data_in)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        check_en;
  logic        e_stall, e_breq, e_bwr, e_iowr, e_iord, e_rv, e_zero;
  logic [15:0] e_rdata, e_bdata, e_ioaddr, e_iodata, pin_val;
  logic [14:0] e_baddr;
  logic [1:0]  e_bmask;
  int          pin_now;
  logic [15:0] last_result;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (check_en) begin
      chk("stall", stall, e_stall);
      chk("bus_request", bus_request, e_breq);
      chk("bus_wr", bus_wr, e_bwr);
      chk("io_wr", io_wr, e_iowr);
      chk("io_rd", io_rd, e_iord);
      chk("result_valid", result_valid, e_rv);
      chk("result_data", result_data, e_rdata);
      if (e_breq) begin
        chk("bus_addr", bus_addr, e_baddr);
        chk("bus_wr_mask", bus_wr_mask, e_bmask);
        if (e_bwr) chk("bus_data_out", bus_data_out, e_bdata);
      end
      if (e_iowr || e_iord) chk("io_addr", io_addr, e_ioaddr);
      if (e_iowr) chk("io_data_out", io_data_out, e_iodata);
      if (e_zero) begin
        chk("zero_bus_addr", bus_addr, 0);
        chk("zero_bus_mask", bus_wr_mask, 0);
        chk("zero_bus_data", bus_data_out, 0);
        chk("zero_io_addr", io_addr, 0);
        chk("zero_io_data", io_data_out, 0);
      end
      case (pin_now)
        1: chk("pin_result_data", result_data, pin_val);
        2: chk("pin_bus_addr", bus_addr, pin_val);
        3: chk("pin_io_data_out", io_data_out, pin_val);
        default: ;
      endcase
    end
  end

  // Expected load/peek result straight from the lane rules, using integer arithmetic
  function automatic logic [15:0] model_result(int kind, logic [1:0] mask, logic sx, logic [15:0] d);
    int b;
    if (kind == K_PEEK || mask == 2'b11) return d;
    b = (mask == 2'b10) ? int'(d) / 256 : int'(d) % 256;
    if (sx && b >= 128) b = b - 256;
    return b[15:0];
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycles(input int n, input logic zero);
    store_memory = 0; load_memory = 0; port_wr = 0; port_rd = 0; bus_grant = 0;
    e_stall = 0; e_breq = 0; e_bwr = 0; e_iowr = 0; e_iord = 0; e_rv = 0;
    e_rdata = last_result; e_zero = zero; pin_now = 0;
    repeat (n) step();
  endtask

  // One access from its IDLE request cycle (k=0) through its DONE cycle; requests stay held while stalled
  task automatic txn(input int kind, input logic [15:0] addr, input logic [15:0] wdata,
                     input logic [1:0] mask, input logic sx, input int waits, input logic [15:0] rdata,
                     input bit also_port_rd, input bit hold_grant, input int pin_sel, input logic [15:0] pin_v);
    int          done;
    bit          mem, rd;
    logic [15:0] res;
    mem  = (kind == K_STORE) || (kind == K_LOAD);
    rd   = (kind == K_LOAD) || (kind == K_PEEK);
    done = mem ? waits + (rd ? 3 : 2) : (rd ? 3 : 2);
    res  = model_result(kind, mask, sx, rdata);
    e_zero = 0;
    for (int k = 0; k <= done; k++) begin
      store_memory = (kind == K_STORE);
      load_memory  = (kind == K_LOAD);
      port_wr      = (kind == K_POKE);
      port_rd      = (kind == K_PEEK) || also_port_rd;
      load_store_address = (k == 0) ? (mem ? addr : 16'h7776) : ~addr;
      port_address       = (k == 0) ? (mem ? 16'h3332 : addr) : ~addr;
      memory_out         = (k == 0) ? (mem ? wdata : 16'h1111) : ~wdata;
      port_out           = (k == 0) ? (mem ? 16'h2222 : wdata) : ~wdata;
      memory_wr_mask     = (k == 0) ? mask : ~mask;
      load_sx            = (k == 0) ? sx : ~sx;
      bus_grant   = mem && (hold_grant ? (k >= waits + 1) : (k == waits + 1));
      bus_data_in = (kind == K_LOAD && k == waits + 2) ? rdata : 16'hC3C3;
      io_data_in  = (kind == K_PEEK && k == 2) ? rdata : 16'h3C3C;
      e_stall  = (k < done);
      e_breq   = mem && (k >= 1) && (k <= waits + 1);
      e_bwr    = e_breq && (kind == K_STORE);
      e_iowr   = (kind == K_POKE) && (k == 1);
      e_iord   = (kind == K_PEEK) && (k == 1);
      e_rv     = rd && (k == done);
      if (rd && k == done) last_result = res;
      e_rdata  = last_result;
      e_baddr  = addr[15:1];
      e_bmask  = mask;
      e_bdata  = wdata;
      e_ioaddr = addr;
      e_iodata = wdata;
      pin_val  = pin_v;
      pin_now  = ((pin_sel == 1 && k == done) || (pin_sel != 1 && k == 1)) ? pin_sel : 0;
      step();
    end
    pin_now = 0;
  endtask

  initial begin
    RST = 1; check_en = 0; last_result = 16'h0;
    store_memory = 0; load_memory = 0; port_wr = 0; port_rd = 0; load_sx = 0; bus_grant = 0;
    load_store_address = 0; memory_out = 0; memory_wr_mask = 0; port_address = 0; port_out = 0;
    bus_data_in = 0; io_data_in = 0;
    e_stall = 0; e_breq = 0; e_bwr = 0; e_iowr = 0; e_iord = 0; e_rv = 0; e_zero = 0;
    e_rdata = 0; e_bdata = 0; e_ioaddr = 0; e_iodata = 0; e_baddr = 0; e_bmask = 0;
    pin_now = 0; pin_val = 0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 0; check_en = 1;
    idle_cycles(2, 1'b1);

    txn(K_STORE, 16'h1234, 16'hBEEF, 2'b11, 1'b0, 2, 16'h0, 0, 0, 2, 16'h091A);
    txn(K_LOAD,  16'h0011, 16'h0000, 2'b10, 1'b1, 0, 16'h80AA, 0, 0, 1, 16'hFF80);
    txn(K_LOAD,  16'h0010, 16'h0000, 2'b01, 1'b0, 0, 16'h80AA, 0, 0, 1, 16'h00AA);
    txn(K_POKE,  16'h0004, 16'h5A5A, 2'b11, 1'b0, 0, 16'h0, 0, 0, 3, 16'h5A5A);
    txn(K_PEEK,  16'h0004, 16'h0000, 2'b11, 1'b0, 0, 16'h1357, 0, 0, 1, 16'h1357);
    txn(K_STORE, 16'h0020, 16'h00C0, 2'b01, 1'b0, 1, 16'h0, 1, 0, 0, 16'h0);
    txn(K_LOAD,  16'h0042, 16'h0000, 2'b11, 1'b1, 3, 16'h8001, 0, 1, 1, 16'h8001);
    txn(K_LOAD,  16'h0100, 16'h0000, 2'b01, 1'b1, 1, 16'h12F0, 0, 0, 1, 16'hFFF0);
    txn(K_LOAD,  16'h0101, 16'h0000, 2'b10, 1'b0, 0, 16'hA512, 0, 0, 1, 16'h00A5);
    txn(K_PEEK,  16'h00F0, 16'h0000, 2'b10, 1'b1, 0, 16'h80FF, 0, 0, 1, 16'h80FF);
    txn(K_STORE, 16'hFFFE, 16'h0102, 2'b10, 1'b0, 0, 16'h0, 0, 0, 2, 16'h7FFF);
    idle_cycles(1, 1'b0);

    // Reset lands while a store waits for grant; the grant after reset must not produce a write
    store_memory = 1; load_storeless_setup();
    e_stall = 1; e_breq = 0; e_bwr = 0; e_iowr = 0; e_iord = 0; e_rv = 0; e_zero = 0;
    e_rdata = last_result; e_baddr = 15'h1234; e_bmask = 2'b11; e_bdata = 16'h1357;
    step();
    e_breq = 1; e_bwr = 1;
    repeat (2) step();
    check_en = 0; RST = 1; store_memory = 0;
    step();
    RST = 0; check_en = 1; last_result = 16'h0;
    bus_grant = 1;
    e_stall = 0; e_breq = 0; e_bwr = 0; e_rdata = 16'h0; e_zero = 1;
    step();
    idle_cycles(1, 1'b1);

    txn(K_LOAD, 16'h0202, 16'h0000, 2'b11, 1'b0, 1, 16'h4321, 0, 0, 1, 16'h4321);
    idle_cycles(2, 1'b0);

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic load_storeless_setup();
    load_memory = 0; port_wr = 0; port_rd = 0; bus_grant = 0;
    load_store_address = 16'h2468; memory_out = 16'h1357; memory_wr_mask = 2'b11; load_sx = 0;
  endtask

endmodule
